// File: rtl/irq_pending_ctrl.sv
// Synchronises 8 interrupt request lines and latches them into a pending vector; an ack clears one bit.
// Latency SYNC_STAGES cycles from input sample to pending/A. No backpressure: overrun flags record lost requests.
module irq_pending_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int LEVEL_MODE  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] irq_in,
   input  logic [7:0] mask,
   input  logic       ack,
   input  logic [2:0] ack_idx,
   input  logic       ovr_clr,
   output logic [7:0] A,
   output logic       irq_valid,
   output logic [7:0] overrun
);

   logic [SYNC_STAGES-1:0][7:0] sync;
   logic [7:0] irq_s;
   logic [7:0] irq_d;
   logic [7:0] pending;
   logic [7:0] set;
   logic [7:0] clr;
   logic [7:0] ovr_set;
   logic [7:0] pending_nxt;
   logic [7:0] overrun_nxt;

   assign irq_s = sync[SYNC_STAGES-1];

   always_comb begin
      set         = 8'h00;
      clr         = 8'h00;
      ovr_set     = 8'h00;
      pending_nxt = 8'h00;
      overrun_nxt = 8'h00;

      if (LEVEL_MODE != 0) begin
         set = irq_s;
      end else begin
         set = irq_s & ~irq_d;
      end

      for (int i = 0; i < 8; i++) begin
         clr[i] = ack & en & (ack_idx == 3'(i));
      end

      // Set dominates a same-cycle ack; an ack on a non-pending bit is a no-op.
      pending_nxt = set | (pending & ~clr);

      if (LEVEL_MODE == 0) begin
         ovr_set = set & pending & ~clr;
      end

      overrun_nxt = ovr_set | (ovr_clr ? 8'h00 : overrun);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync    <= '0;
         irq_d   <= 8'h00;
         pending <= 8'h00;
         overrun <= 8'h00;
      end else begin
         sync[0] <= irq_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync[s] <= sync[s-1];
         end
         irq_d   <= irq_s;
         pending <= pending_nxt;
         overrun <= overrun_nxt;
      end
   end

   assign A         = en ? (pending & mask) : 8'h00;
   assign irq_valid = |A;

endmodule
